pc_gen_btb: RTL

Parametrised fetch-address generator for the IF stage. It is the successor of the single-width PC register.
- Holds the current fetch PC and computes the next one.
- Arbitrates trap redirect, resolved branch/jump redirect, stall, BTB prediction and sequential increment.
- Contains a direct-mapped branch target buffer, trained by the EX stage, so predicted-taken branches redirect fetch with zero bubbles.

---
 rtl/pc_pkg.sv | 60 ++++++
 rtl/pc_btb.sv | 87 ++++++++
 rtl/pc_gen_btb.sv | 88 ++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// +--------------------------------------------------------------------------+
// | pc_pkg : shared types, counter encodings and helpers for pc_gen_btb.      |
// | Macro PC_BTB_HYST_EN selects 2-bit hysteresis counters (else 1-bit).      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package pc_pkg;

  localparam int unsigned DEF_XLEN         = 32;
  localparam int unsigned DEF_BTB_DEPTH    = 16;
  localparam int unsigned DEF_IDX_W        = $clog2(DEF_BTB_DEPTH);
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

`ifdef PC_BTB_HYST_EN
  localparam int unsigned CTR_W = 2;
`else
  localparam int unsigned CTR_W = 1;
`endif

  typedef logic [CTR_W-1:0] ctr_t;

`ifdef PC_BTB_HYST_EN
  localparam ctr_t CTR_SNT   = 2'b00;
  localparam ctr_t CTR_WNT   = 2'b01;
  localparam ctr_t CTR_WT    = 2'b10;
  localparam ctr_t CTR_ST    = 2'b11;
  localparam ctr_t CTR_ALLOC = CTR_WT;
`else
  localparam ctr_t CTR_NT    = 1'b0;
  localparam ctr_t CTR_T     = 1'b1;
  localparam ctr_t CTR_ALLOC = CTR_T;
`endif

  localparam ctr_t CTR_MAX = '1;
  localparam ctr_t CTR_MIN = '0;

  // Entry layout for the default geometry; pc_btb resizes it per instance.
  typedef struct packed {
    logic                              valid;
    logic [DEF_XLEN-DEF_IDX_W-3:0]     tag;
    logic [DEF_XLEN-3:0]               target;
    ctr_t                              ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_MAX) ? c : c + ctr_t'(1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == CTR_MIN) ? c : c - ctr_t'(1);
  endfunction

  function automatic logic ctr_taken(input ctr_t c);
    return c[CTR_W-1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_btb.sv
// +--------------------------------------------------------------------------+
// | pc_btb : direct-mapped branch target buffer, async lookup, sync update.   |
// | Counter width follows PC_BTB_HYST_EN (see pc_pkg).                        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_btb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned BTB_DEPTH = DEF_BTB_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [XLEN-3:0]   target;
    ctr_t              ctr;
  } entry_t;

  entry_t r_btb [BTB_DEPTH];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  entry_t           w_lk_entry;
  logic             w_lk_hit;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  entry_t           w_up_entry;
  logic             w_up_hit;
  logic             w_unused;

  assign w_lk_idx   = lookup_pc[IDX_W+1:2];
  assign w_lk_tag   = lookup_pc[XLEN-1:IDX_W+2];
  assign w_lk_entry = r_btb[w_lk_idx];
  assign w_lk_hit   = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);

  assign pred_taken  = w_lk_hit && ctr_taken(w_lk_entry.ctr);
  assign pred_target = pred_taken ? {w_lk_entry.target, 2'b00} : '0;

  assign w_up_idx   = upd_pc[IDX_W+1:2];
  assign w_up_tag   = upd_pc[XLEN-1:IDX_W+2];
  assign w_up_entry = r_btb[w_up_idx];
  assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

  assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Only valid bits are cleared; stale tag/target/ctr are masked by valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_btb[i].valid <= 1'b0;
      end
    end else if (upd_valid) begin
      if (w_up_hit) begin
        if (upd_taken) begin
          r_btb[w_up_idx].ctr    <= ctr_inc(w_up_entry.ctr);
          r_btb[w_up_idx].target <= upd_target[XLEN-1:2];
        end else begin
          r_btb[w_up_idx].ctr    <= ctr_dec(w_up_entry.ctr);
        end
      end else if (upd_taken) begin
        r_btb[w_up_idx] <= '{valid:  1'b1,
                             tag:    w_up_tag,
                             target: upd_target[XLEN-1:2],
                             ctr:    CTR_ALLOC};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_gen_btb.sv
// +--------------------------------------------------------------------------+
// | pc_gen_btb : IF-stage fetch PC register, redirect priority mux and BTB.   |
// | Optional macro PC_BTB_HYST_EN: 2-bit hysteresis BTB counters.             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_gen_btb
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int unsigned     BTB_DEPTH    = DEF_BTB_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            j_br,
  input  logic [XLEN-1:0] bta,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] PC_IF,
  output logic [XLEN-1:0] PC_next,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [XLEN-1:0] r_pc_if;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_seq;
  logic            w_btb_taken;
  logic [XLEN-1:0] w_btb_target;
  logic            w_unused;

  pc_btb #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .lookup_pc   (r_pc_if),
    .pred_taken  (w_btb_taken),
    .pred_target (w_btb_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  assign pred_taken  = !reset && w_btb_taken;
  assign pred_target = pred_taken ? w_btb_target : '0;
  assign w_pc_seq    = r_pc_if + XLEN'(4);
  assign w_unused    = ^{trap_vec[1:0], bta[1:0]};

  // Redirects outrank stall so a flush is never lost behind back-pressure.
  always_comb begin
    w_pc_next = w_pc_seq;
    if (reset) begin
      w_pc_next = RESET_VECTOR;
    end else if (trap) begin
      w_pc_next = {trap_vec[XLEN-1:2], 2'b00};
    end else if (j_br) begin
      w_pc_next = {bta[XLEN-1:2], 2'b00};
    end else if (stall) begin
      w_pc_next = r_pc_if;
    end else if (pred_taken) begin
      w_pc_next = pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_if <= RESET_VECTOR;
    end else begin
      r_pc_if <= w_pc_next;
    end
  end

  assign PC_IF   = r_pc_if;
  assign PC_next = w_pc_next;

endmodule

`default_nettype wire
